// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bus path: arbiter FSM states and the
// word offsets of the AXI-Lite GPIO register map.
package gpio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  // Word offsets (byte address >> 2) of the GPIO bridge registers.
  localparam logic [6:0] GPIO_DATA   = 7'h00;
  localparam logic [6:0] GPIO_TRI    = 7'h01;
  localparam logic [6:0] GPIO_DATA2  = 7'h02;
  localparam logic [6:0] GPIO_TRI2   = 7'h03;
  localparam logic [6:0] GPIO_GIER   = 7'h47;
  localparam logic [6:0] GPIO_IP_ISR = 7'h48;
  localparam logic [6:0] GPIO_IP_IER = 7'h4A;

endpackage

// File: rtl/gpio_bus_arbiter_if.sv
// Simple-bus link between the arbiter (master) and the GPIO bridge (slave).
// dat_r is registered in the slave and valid the cycle after ack.
interface gpio_bus_arbiter_if #(
  parameter int ADR_W = 7
);

  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [3:0]       byte_sel;
  logic [31:0]      dat_w;
  logic [31:0]      dat_r;
  logic             ack;

  modport master (
    output stb, we, adr, byte_sel, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  stb, we, adr, byte_sel, dat_w,
    output dat_r, ack
  );

endinterface

// File: rtl/gpio_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set request bit at
// or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  logic [IDW:0] pos;

  // Scan from the farthest offset down so the nearest requester is written last.
  // NOTE: every output gets a default before the loop, so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    pos   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      pos = {1'b0, ptr} + (IDW + 1)'(off);
      if (pos >= (IDW + 1)'(N)) begin
        pos = pos - (IDW + 1)'(N);
      end
      if (req[pos[IDW-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing one simple-bus slave port between NUM_REQ
// requesters; one downstream transaction per grant, response one cycle after ack.
module gpio_bus_arbiter
  import gpio_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int ADR_W   = 7,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_stb_i,
  input  logic [NUM_REQ-1:0]       req_we_i,
  input  logic [NUM_REQ*ADR_W-1:0] req_adr_i,
  input  logic [NUM_REQ*4-1:0]     req_byte_sel_i,
  input  logic [NUM_REQ*32-1:0]    req_dat_i,
  output logic [31:0]              req_dat_o,
  output logic [NUM_REQ-1:0]       req_ack_o,
  gpio_bus_arbiter_if.master       bus,
  output logic                     busy_o,
  output logic [IDW-1:0]           grant_o
);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, grant_q, pick_idx;
  logic             pick_valid;
  logic             we_q;
  logic [ADR_W-1:0] adr_q;
  logic [3:0]       sel_q;
  logic [31:0]      dat_q;

  logic [ADR_W-1:0] adr_arr [NUM_REQ];
  logic [3:0]       sel_arr [NUM_REQ];
  logic [31:0]      dat_arr [NUM_REQ];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
    assign adr_arr[r] = req_adr_i[r*ADR_W +: ADR_W];
    assign sel_arr[r] = req_byte_sel_i[r*4 +: 4];
    assign dat_arr[r] = req_dat_i[r*32 +: 32];
  end

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_pick (
    .req   (req_stb_i),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pick_valid) state_d = ST_BUSY;
      ST_BUSY: if (bus.ack)    state_d = ST_RESP;
      ST_RESP:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // stb drops in RESP, so the slave never sees a second strobe for one grant.
  always_comb begin
    bus.stb   = (state_q == ST_BUSY);
    busy_o    = (state_q != ST_IDLE);
    req_ack_o = '0;
    req_dat_o = '0;
    if (state_q == ST_RESP) begin
      req_ack_o[grant_q] = 1'b1;
      req_dat_o          = bus.dat_r;
    end
  end

  // Winner's fields are captured once at the decision and held until the next one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_q  <= '0;
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && pick_valid) begin
        grant_q <= pick_idx;
        we_q    <= req_we_i[pick_idx];
        adr_q   <= adr_arr[pick_idx];
        sel_q   <= sel_arr[pick_idx];
        dat_q   <= dat_arr[pick_idx];
      end
      if (state_q == ST_RESP) begin
        rr_ptr_q <= (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  assign bus.we       = we_q;
  assign bus.adr      = adr_q;
  assign bus.byte_sel = sel_q;
  assign bus.dat_w    = dat_q;
  assign grant_o      = grant_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Randomised bench for gpio_bus_arbiter at NUM_REQ = 2 and 3, checked cycle by
// cycle against a transaction-level round-robin model and a behavioural slave.
module tb_gpio_bus_arbiter;
  import gpio_pkg::*;

  localparam int ADR_W = 7;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Requester drive (shared by both DUTs; the 2-port DUT ignores requester 2)
  logic             q_stb [3];
  logic             q_we  [3];
  logic [ADR_W-1:0] q_adr [3];
  logic [3:0]       q_sel [3];
  logic [31:0]      q_dat [3];

  logic [ADR_W-1:0] ofs [7] = '{GPIO_DATA, GPIO_TRI, GPIO_DATA2, GPIO_TRI2,
                                GPIO_GIER, GPIO_IP_ISR, GPIO_IP_IER};

  logic [1:0]  ack2;
  logic [2:0]  ack3;
  logic [31:0] rdat2, rdat3;
  logic        busy2, busy3;
  logic [0:0]  grant2;
  logic [1:0]  grant3;

  gpio_bus_arbiter_if #(.ADR_W(ADR_W)) bus2 ();
  gpio_bus_arbiter_if #(.ADR_W(ADR_W)) bus3 ();

  gpio_bus_arbiter #(.NUM_REQ(2), .ADR_W(ADR_W)) dut2 (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_stb_i      ({q_stb[1], q_stb[0]}),
    .req_we_i       ({q_we[1], q_we[0]}),
    .req_adr_i      ({q_adr[1], q_adr[0]}),
    .req_byte_sel_i ({q_sel[1], q_sel[0]}),
    .req_dat_i      ({q_dat[1], q_dat[0]}),
    .req_dat_o      (rdat2),
    .req_ack_o      (ack2),
    .bus            (bus2.master),
    .busy_o         (busy2),
    .grant_o        (grant2)
  );

  gpio_bus_arbiter #(.NUM_REQ(3), .ADR_W(ADR_W)) dut3 (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_stb_i      ({q_stb[2], q_stb[1], q_stb[0]}),
    .req_we_i       ({q_we[2], q_we[1], q_we[0]}),
    .req_adr_i      ({q_adr[2], q_adr[1], q_adr[0]}),
    .req_byte_sel_i ({q_sel[2], q_sel[1], q_sel[0]}),
    .req_dat_i      ({q_dat[2], q_dat[1], q_dat[0]}),
    .req_dat_o      (rdat3),
    .req_ack_o      (ack3),
    .bus            (bus3.master),
    .busy_o         (busy3),
    .grant_o        (grant3)
  );

  // Behavioural slaves: ack after 0..lat_max cycles, read data registered on ack
  logic             slave_en = 1'b1;
  logic             spur_ack = 1'b0;
  int               lat_max  = 0;
  logic             ds_stb [2];
  logic [ADR_W-1:0] ds_adr [2];
  logic             ds_ack [2];
  logic [31:0]      ds_rdat [2];
  int               ds_cnt [2];

  assign ds_stb[0]  = bus2.stb;
  assign ds_stb[1]  = bus3.stb;
  assign ds_adr[0]  = bus2.adr;
  assign ds_adr[1]  = bus3.adr;
  assign bus2.ack   = ds_ack[0] | spur_ack;
  assign bus3.ack   = ds_ack[1] | spur_ack;
  assign bus2.dat_r = ds_rdat[0];
  assign bus3.dat_r = ds_rdat[1];

  function automatic logic [31:0] rd_val(input logic [ADR_W-1:0] a);
    return 32'hA5A5_0001 + {17'd0, a, 8'd0};
  endfunction

  function automatic int new_lat();
    return (lat_max == 0) ? 0 : int'($urandom_range(0, lat_max));
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_ni) begin
        ds_ack[k]  <= 1'b0;
        ds_rdat[k] <= '0;
        ds_cnt[k]  <= 0;
      end else begin
        ds_ack[k] <= 1'b0;
        if (ds_ack[k]) begin
          ds_rdat[k] <= rd_val(ds_adr[k]);
          ds_cnt[k]  <= new_lat();
        end else if (ds_stb[k] && slave_en) begin
          if (ds_cnt[k] == 0) ds_ack[k] <= 1'b1;
          else                ds_cnt[k] <= ds_cnt[k] - 1;
        end
      end
    end
  end

  // Observation mux: sel3 selects which DUT the model follows
  logic             sel3 = 1'b0;
  logic [2:0]       o_ack;
  logic [31:0]      o_rdat, o_wdat;
  logic             o_stb, o_we, o_busy;
  logic [ADR_W-1:0] o_adr;
  logic [3:0]       o_sel;
  logic [1:0]       o_grant;

  always_comb begin
    if (sel3) begin
      o_ack = ack3;          o_rdat = rdat3;         o_busy  = busy3;
      o_stb = bus3.stb;      o_we   = bus3.we;       o_adr   = bus3.adr;
      o_sel = bus3.byte_sel; o_wdat = bus3.dat_w;    o_grant = grant3;
    end else begin
      o_ack = {1'b0, ack2};  o_rdat = rdat2;         o_busy  = busy2;
      o_stb = bus2.stb;      o_we   = bus2.we;       o_adr   = bus2.adr;
      o_sel = bus2.byte_sel; o_wdat = bus2.dat_w;    o_grant = {1'b0, grant2};
    end
  end

  // Reference model: pending grant, latched fields, rr pointer, requester budgets
  int               m_ptr, m_win;
  bit               m_inflight, m_resp;
  logic             m_we;
  logic [ADR_W-1:0] m_adr;
  logic [3:0]       m_sel;
  logic [31:0]      m_dat;
  int               rem [3];
  int               d_glog [$];
  bit               prev_stb;

  function automatic int nreq();
    return sel3 ? 3 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic new_req(input int r);
    q_stb[r] = 1'b1;
    q_we[r]  = 1'($urandom);
    q_adr[r] = ofs[$urandom_range(0, 6)];
    q_sel[r] = 4'($urandom);
    q_dat[r] = $urandom;
  endtask

  task automatic set_req(input int r, input logic we, input logic [ADR_W-1:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
    rem[r]   = 1;
    q_stb[r] = 1'b1;
    q_we[r]  = we;
    q_adr[r] = adr;
    q_sel[r] = sel;
    q_dat[r] = dat;
  endtask

  task automatic check_cycle();
    logic [2:0] exp_ack;
    exp_ack = m_resp ? 3'(1 << m_win) : 3'b000;
    check("req_ack",  32'(o_ack),   32'(exp_ack));
    check("stb",      32'(o_stb),   32'(m_inflight));
    check("busy",     32'(o_busy),  32'(m_inflight || m_resp));
    check("grant",    32'(o_grant), 32'(m_win));
    check("we",       32'(o_we),    32'(m_we));
    check("adr",      32'(o_adr),   32'(m_adr));
    check("byte_sel", 32'(o_sel),   32'(m_sel));
    check("dat_w",    o_wdat,       m_dat);
    if (m_resp && !m_we) check("rdata", o_rdat, rd_val(m_adr));
    if (o_stb && !prev_stb) d_glog.push_back(int'(o_grant));
    prev_stb = o_stb;
  endtask

  // Advance the model by one cycle, using the inputs driven right now.
  task automatic predict();
    int  n;
    bit  found;
    logic ack_now;
    n       = nreq();
    found   = 1'b0;
    ack_now = (sel3 ? ds_ack[1] : ds_ack[0]) | spur_ack;
    if (m_resp) begin
      m_resp = 1'b0;
      m_ptr  = (m_win + 1) % n;
    end else if (m_inflight) begin
      if (ack_now) begin
        m_inflight = 1'b0;
        m_resp     = 1'b1;
      end
    end else begin
      for (int off = 0; off < n && !found; off++) begin
        int c;
        c = (m_ptr + off) % n;
        if (q_stb[c]) begin
          found      = 1'b1;
          m_win      = c;
          m_inflight = 1'b1;
          m_we       = q_we[c];
          m_adr      = q_adr[c];
          m_sel      = q_sel[c];
          m_dat      = q_dat[c];
        end
      end
    end
  endtask

  task automatic next();
    predict();
    @(negedge clk_i);
    check_cycle();
    if (m_resp) begin
      rem[m_win]--;
      if (rem[m_win] > 0) new_req(m_win);
      else                q_stb[m_win] = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((rem[0] + rem[1] + rem[2] > 0 || m_inflight || m_resp) && k < budget) begin
      next();
      k++;
    end
    check("drain_timeout", 32'(k < budget), 32'd1);
  endtask

  task automatic do_reset();
    rst_ni   = 1'b0;
    spur_ack = 1'b0;
    for (int r = 0; r < 3; r++) begin
      q_stb[r] = 1'b0; q_we[r] = 1'b0; q_adr[r] = '0; q_sel[r] = '0; q_dat[r] = '0;
      rem[r]   = 0;
    end
    m_ptr = 0; m_win = 0; m_inflight = 1'b0; m_resp = 1'b0;
    m_we  = 1'b0; m_adr = '0; m_sel = '0; m_dat = '0;
    prev_stb = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    check("rst_rdat", o_rdat, 32'd0);
    check_cycle();
  endtask

  task automatic random_phase(input int cycles);
    lat_max = 3;
    for (int c = 0; c < cycles; c++) begin
      next();
      for (int r = 0; r < nreq(); r++) begin
        if (!q_stb[r] && $urandom_range(0, 3) == 0) begin
          rem[r] = int'($urandom_range(1, 3));
          new_req(r);
        end
      end
    end
    drain(200);
  endtask

  task automatic check_rotation(input string tag, input int n, input int len);
    check({tag, "_count"}, 32'(d_glog.size()), 32'(len));
    for (int i = 0; i < len && i < d_glog.size(); i++) begin
      check(tag, 32'(d_glog[i]), 32'(i % n));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected $finish before t=500000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- NUM_REQ = 2 ----
    sel3 = 1'b0;
    do_reset();

    // single write by requester 0, immediate slave ack
    lat_max = 0;
    set_req(0, 1'b1, GPIO_TRI, 4'hF, 32'h0000_00FF);
    drain(20);

    // single read by requester 1
    set_req(1, 1'b0, GPIO_DATA, 4'hF, 32'h0);
    drain(20);

    // contention: both request together, three transactions each
    d_glog.delete();
    do_reset();
    lat_max = 1;
    rem[0] = 3; rem[1] = 3;
    new_req(0); new_req(1);
    drain(100);
    check_rotation("grant_seq2", 2, 6);

    // late arrival: requester 1 shows up while requester 0 is stalled in BUSY,
    // and requester 0 scrambles its own fields, which must be ignored
    d_glog.delete();
    slave_en = 1'b0;
    set_req(0, 1'b0, GPIO_DATA2, 4'hF, 32'h0);
    next(); next();
    set_req(1, 1'b1, GPIO_GIER, 4'h3, 32'h1234_5678);
    q_adr[0] = GPIO_IP_IER;
    q_dat[0] = 32'hDEAD_BEEF;
    next(); next(); next();
    slave_en = 1'b1;
    drain(50);
    check("late_count", 32'(d_glog.size()), 32'd2);
    if (d_glog.size() == 2) begin
      check("late_first",  32'(d_glog[0]), 32'd0);
      check("late_second", 32'(d_glog[1]), 32'd1);
    end

    // reset in the middle of a transaction
    slave_en = 1'b0;
    set_req(0, 1'b1, GPIO_TRI2, 4'h5, 32'hCAFE_0000);
    next(); next();
    check("pre_rst_stb", 32'(o_stb), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_stb",  32'(o_stb),  32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ack",  32'(o_ack),  32'd0);
    do_reset();
    slave_en = 1'b1;
    set_req(1, 1'b0, GPIO_DATA, 4'hF, 32'h0);
    drain(20);

    random_phase(600);

    // ---- NUM_REQ = 3 ----
    sel3 = 1'b1;
    do_reset();
    lat_max = 0;
    spur_ack = 1'b1;
    next();
    spur_ack = 1'b0;
    next(); next();

    d_glog.delete();
    lat_max = 2;
    for (int r = 0; r < 3; r++) begin
      rem[r] = 2;
      new_req(r);
    end
    drain(100);
    check_rotation("grant_seq3", 3, 6);

    random_phase(600);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_bus_arbiter.md
Name: gpio_bus_arbiter

Overview:
- Shares one simple-bus slave port between NUM_REQ requesters using round-robin arbitration. Typical requesters: CPU load/store path, debug module, DMA.
- The slave port drives the AXI-Lite GPIO bridge.
- Latches the granted request and holds it stable for the whole transaction. Guarantees exactly one downstream transaction per grant.
- Returns the response to the granted requester one cycle after the downstream ack, so registered slave read data is already valid when it is forwarded.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADR_W, 7, word-address width (9-bit byte address minus 2).
- IDW, $clog2(NUM_REQ) (min 1), grant index width (derived localparam).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_stb_i  in  NUM_REQ  per-requester strobe.
- req_we_i  in  NUM_REQ  per-requester write enable.
- req_adr_i  in  NUM_REQ*ADR_W  packed word addresses; requester r occupies [r*ADR_W +: ADR_W].
- req_byte_sel_i  in  NUM_REQ*4  packed byte enables.
- req_dat_i  in  NUM_REQ*32  packed write data.
- req_dat_o  out  32  read data, shared by all requesters, valid with req_ack_o.
- req_ack_o  out  NUM_REQ  one-hot acknowledge.
- stb_o  out  1  downstream strobe.
- we_o  out  1  downstream write enable.
- adr_o  out  ADR_W  downstream word address.
- byte_sel_o  out  4  downstream byte enables.
- dat_o  out  32  downstream write data.
- dat_i  in  32  downstream read data; registered in the slave, valid the cycle after ack_i.
- ack_i  in  1  downstream acknowledge, one cycle.
- busy_o  out  1  transaction in flight (state != ST_IDLE).
- grant_o  out  IDW  index of the current or most recent grant.

Behaviour:
- Reset values (async, rst_ni low):
  - state = ST_IDLE; stb_o = 0; we_o = 0; adr_o = 0; byte_sel_o = 0; dat_o = 0.
  - req_ack_o = 0; req_dat_o = 0; busy_o = 0; grant_o = 0; rr pointer = 0.
- States: ST_IDLE, ST_BUSY, ST_RESP.
- ST_IDLE:
  - If any req_stb_i is set, choose winner g = first set bit scanning from rr pointer upward, wrapping modulo NUM_REQ.
  - Register g's we/adr/byte_sel/dat onto the downstream outputs and register grant_o = g.
  - Next cycle: stb_o = 1, state -> ST_BUSY.
  - If no request: stay in ST_IDLE, stb_o = 0, outputs hold their last values.
- ST_BUSY:
  - stb_o = 1 and all downstream fields held constant until ack_i.
  - Requester inputs are ignored, including a change or drop of the granted requester's stb.
  - On ack_i: stb_o = 0 from the next cycle; state -> ST_RESP.
- ST_RESP (exactly 1 cycle):
  - req_ack_o[grant_o] = 1; req_dat_o = dat_i, valid for reads and don't-care for writes.
  - rr pointer <= (grant_o + 1) mod NUM_REQ.
  - State -> ST_IDLE.
- Downstream stb_o is 0 in the cycle after ack_i, so the slave never starts a duplicate transaction.
- Requester rule: deassert stb, or present a new request, in the cycle after its ack.
- Minimum per-grant overhead: 1 cycle (IDLE decision) + slave latency + 1 cycle (RESP). A back-to-back request from the same requester is decided in the cycle after RESP.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 grants.
- Simultaneous requests in ST_IDLE: rr order decides; the losers keep stb asserted and are served later.
- A request arriving during ST_BUSY or ST_RESP is held off, not lost; its stb stays high until it is acked.
- ack_i outside ST_BUSY is ignored: no state change, no req_ack_o.
- Reset mid-transaction: immediate return to ST_IDLE, stb_o = 0, no req_ack_o is issued. The downstream bridge shares the reset, so the whole path is reset together.
- Non-power-of-2 NUM_REQ: the rr pointer wraps from NUM_REQ-1 to 0; pointer values >= NUM_REQ never occur.
- There is no timeout: a slave that never acks stalls the arbiter until reset.

Decomposition:
- Shared package gpio_pkg holds: arb_state_t enum (ST_IDLE, ST_BUSY, ST_RESP); GPIO register word-offset constants (DATA = 0x00, TRI = 0x01, DATA2 = 0x02, TRI2 = 0x03, GIER = 0x47, IP_ISR = 0x48, IP_IER = 0x4A).
- One sub-module, rr_pick: combinational round-robin selector (req vector + pointer -> valid, index). Reusable elsewhere in the SoC.

Test Plan:
- Single write: req0 stb, we = 1, adr = 0x01, dat = 0x0000_00FF, sel = 0xF.
  -> stb_o rises 1 cycle later with adr_o = 0x01 and dat_o = 0xFF held.
  -> slave ack at cycle k -> req_ack_o = 2'b01 at k+1 only; stb_o = 0 at k+1.
- Single read: req1 reads adr 0x00; slave returns 0xA5A5_0001, registered.
  -> req_ack_o = 2'b10 with req_dat_o = 0xA5A5_0001 in the same cycle.
- Contention: req0 and req1 both request at cycle 0, each doing 3 transactions.
  -> grant sequence 0,1,0,1,0,1.
  -> exactly 6 stb_o rising edges; no duplicate downstream transaction.
- Late arrival: req1 raises stb mid ST_BUSY of req0.
  -> downstream fields stay unchanged; req1 is granted in the first ST_IDLE after req0's ST_RESP.
- Reset mid-op: assert rst_ni low during ST_BUSY.
  -> stb_o = 0, busy_o = 0, req_ack_o = 0 asynchronously; after release, a fresh request completes normally.
- NUM_REQ = 3, all requesting continuously.
  -> grants 0,1,2,0,1,2; spurious ack_i in ST_IDLE produces no req_ack_o.
